// File: rtl/mod_counter_stage.sv
// Modulo-MODULUS up/down counter stage with synchronous clear/preset and
// combinational carry/borrow strobes for zero-latency cascading on one clock.
module mod_counter_stage #(
  parameter int MODULUS = 60,
  parameter int WIDTH   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_up,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_carry,
  output logic             o_borrow,
  output logic             o_at_max
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             at_max;
  logic             at_zero;
  logic             step_ok;

  assign at_max  = (cnt_q == MAX_CNT);
  assign at_zero = (cnt_q == '0);

  // A step only happens when nothing of higher priority claims the edge.
  assign step_ok = rst_n & i_en & ~i_clr & ~i_load;

  // NOTE: cnt_d gets a default before any branch so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_load) begin
      cnt_d = (i_load_val > MAX_CNT) ? MAX_CNT : i_load_val;
    end else if (i_en) begin
      // Wrap is an explicit compare so MODULUS == 2**WIDTH needs no overflow.
      if (i_up) begin
        cnt_d = at_max ? '0 : cnt_q + WIDTH'(1);
      end else begin
        cnt_d = at_zero ? MAX_CNT : cnt_q - WIDTH'(1);
      end
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt    = cnt_q;
  assign o_at_max = at_max;
  assign o_carry  = step_ok &  i_up & at_max;
  assign o_borrow = step_ok & ~i_up & at_zero;

endmodule
